mem8_ctrl_arb: RTL and testbench
================================

Name: mem8_ctrl_arb

Overview:
Two-requester arbiter and sequencer for the 8-byte register-cell memory.
It accepts byte read/write requests from requesters A and B and arbitrates them round-robin.
It drives the memory's active-low read/write strobes and one-hot byte enables in a fixed setup/strobe/capture sequence, and returns read data with a per-requester done pulse.
It sits between bus-side masters and the 8-byte memory array.

Parameters:
DATA_W, 8, byte width of memory and request data
ADDR_W, 3, address width; depth = 2**ADDR_W = 8 bytes

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
a_req  in  1  requester A request, held until a_done
a_we  in  1  A: 1 = write, 0 = read
a_addr  in  ADDR_W  A byte address
a_wdata  in  DATA_W  A write data
a_gnt  out  1  A granted; high from SETUP through RESP
a_done  out  1  one-cycle completion pulse to A
a_rdata  out  DATA_W  A read data, valid with a_done on reads
b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata: same as A, for requester B
mem_en  out  2**ADDR_W  one-hot byte enable to memory
mem_din  out  DATA_W  write data bus to all cells
mem_rd_bar  out  1  active-low read strobe
mem_wr_bar  out  1  active-low write strobe
mem_dout  in  DATA_W  memory read data; registered in memory, valid the cycle after mem_rd_bar=0 at a clk edge
busy  out  1  high whenever FSM is not in IDLE

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM to IDLE; mem_rd_bar=1, mem_wr_bar=1, mem_en=0, mem_din=0.
  - All gnt/done = 0; a_rdata = b_rdata = 0; busy = 0.
  - Round-robin pointer = A (A has priority on the first contention).
- Reset mid-operation: all outputs return to reset values immediately; the in-flight access is abandoned and a write may or may not have landed. No done pulse is issued after reset releases; requesters must re-request.
- FSM states: IDLE, SETUP, STROBE, CAPTURE, RESP.
- IDLE: sample a_req/b_req each cycle.
  - Only one requester high: grant it.
  - Both high: grant the pointer side.
  - On grant, latch we/addr/wdata of the winner into internal registers and go to SETUP. Later requester input changes are ignored.
- SETUP, 1 cycle:
  - mem_en = one-hot(addr latch); mem_din = wdata latch (write) or 0 (read); both strobes high.
  - Next state: STROBE.
- STROBE, 1 cycle:
  - Write: mem_wr_bar=0; memory captures at the end-of-cycle edge.
  - Read: mem_rd_bar=0.
  - mem_en and mem_din held.
  - Next state: CAPTURE on read, RESP on write.
- CAPTURE, 1 cycle, reads only:
  - Strobes high, mem_en held.
  - Winner's rdata register loads mem_dout at the end of the cycle.
  - Next state: RESP.
- RESP, 1 cycle:
  - Winner's done = 1; mem_en = 0; strobes high.
  - Pointer moves to the other requester.
  - Next state: IDLE.
- Latency from req sampled in IDLE to done: write 3 cycles (SETUP, STROBE, RESP); read 4 cycles.
- Back-to-back operation:
  - A requester must drop req in the cycle after done or it is re-arbitrated as a new request.
  - IDLE lasts a minimum of 1 cycle between transactions, so sustained throughput is one access per 4 (write) or 5 (read) cycles.
- Fairness: with both requesting continuously, grants alternate A, B, A, B...
- Strobe rules: mem_rd_bar and mem_wr_bar are never both 0. A strobe is never 0 while mem_en == 0. Strobes are driven from registers (glitch-free).
- rdata persistence:
  - rdata holds its last value until the next read completion for that requester.
  - Writes do not change rdata.
- Unused requester (req tied 0) never receives gnt or done.

Decomposition:
- Shared package: state encoding constants (IDLE=0, SETUP=1, STROBE=2, CAPTURE=3, RESP=4, 3-bit), DATA_W/ADDR_W defaults, and a one-hot address decode function.
- One sub-module is natural: rr_arb2, the 2-way round-robin arbiter (req[1:0], advance pulse, pointer register, gnt[1:0]).
- The FSM, latches and memory drive stay in the top module.

Test Plan:
1. Reset: assert rst_n=0 mid-STROBE of an A write -> all strobes 1, mem_en=0, busy=0 within the same cycle; no a_done after release.
2. A single write: A writes addr 3 = 8'hA5 -> mem_en=8'b0000_1000 in SETUP; mem_wr_bar=0 for exactly one cycle; a_done pulses 3 cycles after request; a subsequent read of addr 3 returns a_rdata=8'hA5.
3. B single read: B reads addr 7 after a write of 8'h3C -> mem_rd_bar=0 one cycle; b_rdata=8'h3C with b_done 4 cycles after request; a_rdata unchanged.
4. Contention: a_req and b_req raised in the same cycle after reset -> A served first, then B; with both held continuously for 4 transactions, the grant order is A, B, A, B.
5. Input change after grant: change a_addr and a_wdata during SETUP -> memory sees the originally latched address and data.
6. Strobe invariants: random traffic for 1000 cycles -> checker never sees both strobes low, never sees a strobe low with mem_en=0, and mem_en is always zero or one-hot.

Source files
------------

// File: rtl/mem8_ctrl_arb_pkg.sv
// Shared definitions for the two-requester 8-byte memory sequencer:
// default widths, FSM state encoding and the one-hot byte-enable decode.
package mem8_ctrl_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_STROBE  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  // Wide enough for any address up to 8 bits; callers cast down to their depth.
  function automatic logic [255:0] onehot_dec(input logic [7:0] addr);
    onehot_dec = 256'd1 << addr;
  endfunction

endpackage

// File: rtl/mem8_ctrl_arb_rr_arb2.sv
// Two-way round-robin arbiter: a single requester always wins, a tie goes to
// the pointer side, and the pointer moves away from the side just served.
module mem8_ctrl_arb_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       adv_idx,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = ~adv_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mem8_ctrl_arb.sv
// Arbiter/sequencer between two byte requesters and the 8-byte register-cell
// memory: setup, strobe, capture (reads only) and response, one access at a time.
module mem8_ctrl_arb
  import mem8_ctrl_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_wdata,
  output logic                 a_gnt,
  output logic                 a_done,
  output logic [DATA_W-1:0]    a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_wdata,
  output logic                 b_gnt,
  output logic                 b_done,
  output logic [DATA_W-1:0]    b_rdata,
  output logic [2**ADDR_W-1:0] mem_en,
  output logic [DATA_W-1:0]    mem_din,
  output logic                 mem_rd_bar,
  output logic                 mem_wr_bar,
  input  logic [DATA_W-1:0]    mem_dout,
  output logic                 busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [2:0]        state_q, state_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic [DEPTH-1:0]  mem_en_q, mem_en_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              rd_bar_q, rd_bar_d;
  logic              wr_bar_q, wr_bar_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic [1:0]        arb_gnt;
  logic              sel_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  mem8_ctrl_arb_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({b_req, a_req}),
    .advance (state_q == ST_RESP),
    .adv_idx (win_q),
    .gnt     (arb_gnt)
  );

  assign sel_b     = arb_gnt[1];
  assign sel_we    = sel_b ? b_we    : a_we;
  assign sel_addr  = sel_b ? b_addr  : a_addr;
  assign sel_wdata = sel_b ? b_wdata : a_wdata;

  // mem_en/mem_din registers double as the address/data latch of the winner.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    we_d      = we_q;
    mem_en_d  = mem_en_q;
    mem_din_d = mem_din_q;
    rd_bar_d  = 1'b1;
    wr_bar_d  = 1'b1;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_gnt != 2'b00) begin
          state_d   = ST_SETUP;
          win_d     = sel_b;
          we_d      = sel_we;
          mem_en_d  = DEPTH'(onehot_dec(8'(sel_addr)));
          mem_din_d = sel_we ? sel_wdata : '0;
        end
      end
      ST_SETUP: begin
        state_d  = ST_STROBE;
        rd_bar_d = we_q;
        wr_bar_d = ~we_q;
      end
      ST_STROBE: begin
        if (we_q) begin
          state_d   = ST_RESP;
          mem_en_d  = '0;
          mem_din_d = '0;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_d   = ST_RESP;
        mem_en_d  = '0;
        mem_din_d = '0;
        if (win_q) b_rdata_d = mem_dout;
        else       a_rdata_d = mem_dout;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      mem_en_q  <= '0;
      mem_din_q <= '0;
      rd_bar_q  <= 1'b1;
      wr_bar_q  <= 1'b1;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      we_q      <= we_d;
      mem_en_q  <= mem_en_d;
      mem_din_q <= mem_din_d;
      rd_bar_q  <= rd_bar_d;
      wr_bar_q  <= wr_bar_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign a_gnt      = busy && !win_q;
  assign b_gnt      = busy && win_q;
  assign a_done     = (state_q == ST_RESP) && !win_q;
  assign b_done     = (state_q == ST_RESP) && win_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_din    = mem_din_q;
  assign mem_rd_bar = rd_bar_q;
  assign mem_wr_bar = wr_bar_q;

endmodule

// File: tb/tb_mem8_ctrl_arb.sv
// Randomized and directed bench for mem8_ctrl_arb with a transaction-level
// schedule model and an 8-byte memory model driven by the DUT strobes.
module tb_mem8_ctrl_arb;

  typedef struct packed {
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
  } op_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rq[2], rwe[2];
  logic [2:0] raddr[2];
  logic [7:0] rwd[2];
  logic       gnt[2], done[2];
  logic [7:0] rdata[2];
  logic [7:0] mem_en, mem_din;
  logic [7:0] mem_dout = 8'h00;
  logic       mem_rd_bar, mem_wr_bar, busy;

  always #5 clk = ~clk;

  mem8_ctrl_arb dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(rq[0]), .a_we(rwe[0]), .a_addr(raddr[0]), .a_wdata(rwd[0]),
    .a_gnt(gnt[0]), .a_done(done[0]), .a_rdata(rdata[0]),
    .b_req(rq[1]), .b_we(rwe[1]), .b_addr(raddr[1]), .b_wdata(rwd[1]),
    .b_gnt(gnt[1]), .b_done(done[1]), .b_rdata(rdata[1]),
    .mem_en(mem_en), .mem_din(mem_din), .mem_rd_bar(mem_rd_bar),
    .mem_wr_bar(mem_wr_bar), .mem_dout(mem_dout), .busy(busy)
  );

  // Memory cells: write on wr strobe, registered read on rd strobe.
  logic [7:0] mem [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (mem_en[i] && !mem_wr_bar) mem[i] <= mem_din;
      if (mem_en[i] && !mem_rd_bar) mem_dout <= mem[i];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Transaction-level model: phase counts cycles since the grant.
  logic [7:0] ref_mem [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
  logic [7:0] exp_rd[2];
  op_t        cur;
  int         phase, win, last;

  op_t qa[$], qb[$];
  int  order[$];
  logic done_seen[2], gnt_prev[2], scramble[2];
  int  req_start[2], lat[2];
  int  wr_lo_cnt, rd_lo_cnt, done_cnt;
  logic [7:0] en_at_grant;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    phase = 0; last = 1; cur = '0;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    for (int r = 0; r < 2; r++) begin
      done_seen[r] = 1'b0; gnt_prev[r] = 1'b0; req_start[r] = -1;
    end
  endtask

  task automatic check_cycle();
    int         tot;
    logic [7:0] en_e;
    tot  = cur.we ? 3 : 4;
    en_e = (phase >= 1 && phase <= tot - 1) ? (8'd1 << cur.addr) : 8'd0;
    chk("busy", busy, phase > 0);
    chk("mem_en", mem_en, en_e);
    if (en_e != 8'd0) chk("mem_din", mem_din, cur.we ? cur.wdata : 8'h00);
    chk("mem_wr_bar", mem_wr_bar, !(phase == 2 && cur.we));
    chk("mem_rd_bar", mem_rd_bar, !(phase == 2 && !cur.we));
    chk("strobes_both_low", !mem_rd_bar && !mem_wr_bar, 0);
    chk("strobe_without_en", (!mem_rd_bar || !mem_wr_bar) && mem_en == 8'd0, 0);
    chk("mem_en_onehot", $countones(mem_en) <= 1, 1);
    for (int r = 0; r < 2; r++) begin
      chk(r == 0 ? "a_gnt" : "b_gnt", gnt[r], phase > 0 && win == r);
      chk(r == 0 ? "a_done" : "b_done", done[r], phase == tot && win == r);
      chk(r == 0 ? "a_rdata" : "b_rdata", rdata[r], exp_rd[r]);
      if (gnt[r] && !gnt_prev[r]) begin
        order.push_back(r);
        if (r == 0) en_at_grant = mem_en;
      end
      gnt_prev[r] = gnt[r];
      if (rq[r] && req_start[r] < 0) req_start[r] = cyc;
      if (done[r]) begin
        lat[r] = cyc - req_start[r];
        req_start[r] = -1;
        done_cnt++;
      end
      done_seen[r] = done[r];
    end
    if (!mem_wr_bar) wr_lo_cnt++;
    if (!mem_rd_bar) rd_lo_cnt++;
  endtask

  task automatic model_update();
    int tot;
    tot = cur.we ? 3 : 4;
    if (phase == 0) begin
      if (rq[0] || rq[1]) begin
        if (rq[0] && rq[1]) win = (last == 0) ? 1 : 0;
        else                win = rq[1] ? 1 : 0;
        cur.we = rwe[win]; cur.addr = raddr[win]; cur.wdata = rwd[win];
        phase = 1;
      end
    end else if (phase == tot) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == tot) begin
        if (cur.we) ref_mem[cur.addr] = cur.wdata;
        else        exp_rd[win] = ref_mem[cur.addr];
        last = win;
      end
    end
  endtask

  task automatic drive_agents();
    op_t op;
    for (int r = 0; r < 2; r++) begin
      if (rq[r] && done_seen[r]) begin
        rq[r] = 1'b0;
      end else if (!rq[r] && ((r == 0) ? qa.size() : qb.size()) > 0) begin
        op = (r == 0) ? qa.pop_front() : qb.pop_front();
        rq[r] = 1'b1; rwe[r] = op.we; raddr[r] = op.addr; rwd[r] = op.wdata;
      end else if (rq[r] && scramble[r] && gnt[r]) begin
        raddr[r] = 3'($urandom); rwd[r] = 8'($urandom);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_cycle();
    model_update();
    @(posedge clk);
    #1;
    drive_agents();
  endtask

  task automatic push(input int r, input logic we, input logic [2:0] addr, input logic [7:0] wd);
    op_t op;
    op.we = we; op.addr = addr; op.wdata = wd;
    if (r == 0) qa.push_back(op);
    else        qb.push_back(op);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || rq[0] || rq[1] || phase != 0) && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", n >= budget, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rq[0] = 1'b0; rq[1] = 1'b0;
    qa.delete(); qb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int r = 0; r < 2; r++) begin
      rq[r] = 1'b0; rwe[r] = 1'b0; raddr[r] = 3'd0; rwd[r] = 8'h00; scramble[r] = 1'b0; lat[r] = -1;
    end
    wr_lo_cnt = 0; rd_lo_cnt = 0; done_cnt = 0; en_at_grant = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {gnt[0], gnt[1], done[0], done[1]}, 0);
    chk("rst_rdata", {rdata[0], rdata[1]}, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_strobes", {mem_rd_bar, mem_wr_bar}, 2'b11);
    rst_n = 1'b1;

    // A writes 8'hA5 to address 3, then reads it back.
    wr_lo_cnt = 0;
    push(0, 1'b1, 3'd3, 8'hA5);
    wait_idle(40);
    chk("a_wr_latency", lat[0], 3);
    chk("a_wr_strobe_cycles", wr_lo_cnt, 1);
    chk("a_wr_en_setup", en_at_grant, 8'b0000_1000);
    push(0, 1'b0, 3'd3, 8'h00);
    wait_idle(40);
    chk("a_rd_latency", lat[0], 4);
    chk("a_rd_value", rdata[0], 8'hA5);

    // A writes 8'h3C to address 7, B reads it.
    push(0, 1'b1, 3'd7, 8'h3C);
    wait_idle(40);
    rd_lo_cnt = 0;
    push(1, 1'b0, 3'd7, 8'h00);
    wait_idle(40);
    chk("b_rd_latency", lat[1], 4);
    chk("b_rd_strobe_cycles", rd_lo_cnt, 1);
    chk("b_rd_value", rdata[1], 8'h3C);
    chk("a_rdata_kept", rdata[0], 8'hA5);

    // Address/data wiggle after the grant must not reach memory.
    scramble[0] = 1'b1;
    push(0, 1'b1, 3'd5, 8'h5A);
    wait_idle(40);
    scramble[0] = 1'b0;
    push(0, 1'b0, 3'd5, 8'h00);
    wait_idle(40);
    chk("latched_write_value", rdata[0], 8'h5A);

    // Contention straight after reset: A first, then alternation.
    do_reset();
    order.delete();
    push(0, 1'b1, 3'd0, 8'h01); push(0, 1'b1, 3'd1, 8'h02);
    push(1, 1'b0, 3'd0, 8'h00); push(1, 1'b0, 3'd1, 8'h00);
    wait_idle(80);
    chk("grant_count", order.size(), 4);
    n = 0;
    foreach (order[i]) n = n * 2 + order[i];
    chk("grant_order", n, 4'b0101);

    // Reset in the middle of an A write strobe.
    push(0, 1'b1, 3'd2, 8'hEE);
    n = 0;
    while (mem_wr_bar && n < 10) begin
      step();
      n++;
    end
    chk("reach_strobe_timeout", n >= 10, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_strobes", {mem_rd_bar, mem_wr_bar}, 2'b11);
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_a_gnt", gnt[0], 0);
    rq[0] = 1'b0; rq[1] = 1'b0;
    qa.delete(); qb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ref_mem[2] = mem[2];
    done_cnt = 0;
    repeat (8) step();
    chk("no_done_after_reset", done_cnt, 0);

    // Random traffic on both requesters.
    for (int c = 0; c < 1000; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!rq[r] && ((r == 0) ? qa.size() : qb.size()) == 0 && $urandom_range(0, 3) == 0)
          push(r, 1'($urandom), 3'($urandom), 8'($urandom));
      end
      step();
    end
    wait_idle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
